// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM controller: controller state
// encoding and the default RAM geometry.
package sp_ram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAPT = 3'd3,
    RD_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/sp_ram_ctrl.sv
// Initiator-side controller for one single-port RAM. Host burst commands are
// turned into serialized RAM write beats (one per accepted wr beat) or read
// beats (address, capture, respond). Reads return on a valid/ready stream.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int addr_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [addr_width-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_data,
  output logic                  busy,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wdata,
  input  logic [data_width-1:0] ram_rdata
);

  localparam logic [addr_width-1:0] ADDR_ONE  = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] ADDR_ZERO = {addr_width{1'b0}};
  localparam logic [data_width-1:0] DATA_ZERO = {data_width{1'b0}};

  state_e                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [data_width-1:0] rsp_data_q, rsp_data_d;

  // State, pointer, beat counter and response registers; reset drops any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ADDR_ZERO;
      cnt_q       <= ADDR_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic plus the RAM/handshake strobes. The RAM address always
  // follows the pointer; writes are strobed in the same cycle as the wr beat.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = ptr_q;
    ram_wdata   = DATA_ZERO;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_we ? WR : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_we    = 1'b1;
          ram_wdata = wr_data;
          ptr_d     = ptr_q + ADDR_ONE;
          cnt_d     = cnt_q - ADDR_ONE;
          state_d   = (cnt_q == ADDR_ZERO) ? IDLE : WR;
        end else begin
          state_d = WR;
        end
      end
      RD_ADDR: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RD_RESP;
      end
      RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cnt_q == ADDR_ZERO) begin
            state_d = IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_ONE;
            cnt_d   = cnt_q - ADDR_ONE;
            state_d = RD_ADDR;
          end
        end else begin
          state_d = RD_RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed self-checking bench for sp_ram_ctrl paired with a behavioural
// single-port RAM (registered read, no output update while writing).
module tb_sp_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [3:0] cmd_addr = 4'd0;
  logic [3:0] cmd_len = 4'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  logic [7:0] mem [0:15] = '{default: 8'h00};
  logic [7:0] wbuf [0:15];
  logic [7:0] rd_q [$];

  int n_cmp = 0;
  int n_err = 0;

  sp_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else        ram_rdata     <= mem[ram_addr];
  end

  // Present a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic we, input logic [3:0] addr, input logic [3:0] len);
    int w = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Back-to-back write burst from wbuf
  task automatic do_write(input logic [3:0] addr, input logic [3:0] len);
    send_cmd(1'b1, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      wr_valid = 1'b1; wr_data = wbuf[b];
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  // Read burst, always ready; collects beats into rd_q
  task automatic do_read(input logic [3:0] addr, input logic [3:0] len);
    rd_q.delete();
    send_cmd(1'b0, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      int w = 0;
      while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
      if (!rsp_valid) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_timeout: beat %0d rsp_valid=%0b required 1", b, rsp_valid);
        return;
      end
      rd_q.push_back(rsp_data);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_ready, rsp_valid, busy, ram_we} !== 4'b0000 || rsp_data !== 8'h00 ||
        ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_values: wr_ready=%0b rsp_valid=%0b busy=%0b ram_we=%0b rsp_data=%h ram_addr=%h ram_wdata=%h required all 0",
               wr_ready, rsp_valid, busy, ram_we, rsp_data, ram_addr, ram_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int k;
    send_cmd(1'b1, 4'd3, 4'd0);
    wr_valid = 1'b1; wr_data = 8'hA5;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 4'd3 || ram_wdata !== 8'hA5 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_wr_strobe: we=%0b addr=%h wdata=%h wr_ready=%0b required 1/3/a5/1",
               ram_we, ram_addr, ram_wdata, wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mem[3] !== 8'hA5) begin
      n_err++; $display("FAIL single_wr_done: busy=%0b mem[3]=%h required 0/a5", busy, mem[3]);
    end
    send_cmd(1'b0, 4'd3, 4'd0);
    k = 1;
    while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (k != 3) begin
      n_err++; $display("FAIL read_latency: %0d cycles required 3", k);
    end
    n_cmp++;
    if (rsp_data !== 8'hA5) begin
      n_err++; $display("FAIL single_rd_data: rsp_data=%h required a5", rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_rd_done: rsp_valid=%0b busy=%0b required 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_burst_wrap();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(4'd14, 4'd3);
    n_cmp++;
    if (mem[14] !== 8'h11 || mem[15] !== 8'h22 || mem[0] !== 8'h33 ||
        mem[1] !== 8'h44 || mem[2] !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_write: mem14..2=%h %h %h %h %h required 11 22 33 44 00",
               mem[14], mem[15], mem[0], mem[1], mem[2]);
    end
    do_read(4'd14, 4'd3);
    n_cmp++;
    if (rd_q.size() != 4 || rd_q[0] !== 8'h11 || rd_q[1] !== 8'h22 ||
        rd_q[2] !== 8'h33 || rd_q[3] !== 8'h44) begin
      n_err++; $display("FAIL wrap_read: got %0d beats, first=%h required 4 beats 11 22 33 44",
                        rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 8'hxx);
    end
  endtask

  task automatic test_stalls();
    int w = 0;
    send_cmd(1'b1, 4'd5, 4'd1);
    wr_valid = 1'b1; wr_data = 8'h5A;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 4'd5) begin
      n_err++; $display("FAIL stall_beat0: we=%0b addr=%h required 1/5", ram_we, ram_addr);
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      wr_valid = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b0;
      #1;
      n_cmp++;
      if (ram_we !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL stall_gap%0d: we=%0b cmd_ready=%0b busy=%0b required 0/0/1",
                          s, ram_we, cmd_ready, busy);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hC3;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 4'd6 || ram_wdata !== 8'hC3) begin
      n_err++; $display("FAIL stall_beat1: we=%0b addr=%h wdata=%h required 1/6/c3", ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mem[5] !== 8'h5A || mem[6] !== 8'hC3) begin
      n_err++; $display("FAIL stall_wr_done: busy=%0b mem5=%h mem6=%h required 0/5a/c3", busy, mem[5], mem[6]);
    end
    send_cmd(1'b0, 4'd5, 4'd1);
    while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || ram_we !== 1'b0 || ram_addr !== 4'd5) begin
        n_err++; $display("FAIL rsp_hold%0d: valid=%0b data=%h we=%0b addr=%h required 1/5a/0/5",
                          s, rsp_valid, rsp_data, ram_we, ram_addr);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    w = 0;
    while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3) begin
      n_err++; $display("FAIL stall_rd_beat1: valid=%0b data=%h required 1/c3", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
    do_write(4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[i] !== 8'(i)) begin
        n_err++; $display("FAIL full_write[%0d]: mem=%h required %h", i, mem[i], 8'(i));
      end
    end
    do_read(4'd0, 4'd15);
    n_cmp++;
    if (rd_q.size() != 16) begin
      n_err++; $display("FAIL full_read_count: %0d beats required 16", rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_cmp++;
      if (rd_q[i] !== 8'(i)) begin
        n_err++; $display("FAIL full_read[%0d]: data=%h required %h", i, rd_q[i], 8'(i));
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL full_done_busy: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    send_cmd(1'b1, 4'd8, 4'd3);
    wr_valid = 1'b1; wr_data = 8'hE0;
    @(negedge clk);
    wr_data = 8'hE1;
    @(negedge clk);
    wr_data = 8'hE2;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_wr_reset: we=%0b busy=%0b wr_ready=%0b required 0/0/0", ram_we, busy, wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_wr_release: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
    n_cmp++;
    if (mem[8] !== 8'hE0 || mem[9] !== 8'hE1 || mem[10] !== 8'h0A || mem[11] !== 8'h0B) begin
      n_err++; $display("FAIL mid_wr_mem: mem8..11=%h %h %h %h required e0 e1 0a 0b",
                        mem[8], mem[9], mem[10], mem[11]);
    end
    @(negedge clk);
    send_cmd(1'b0, 4'd2, 4'd1);
    while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_rd_reset: valid=%0b data=%h busy=%0b required 0/00/0", rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_stalls();
    test_full_depth();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
